// File: rtl/my_mst_stream_merger.sv
// NCH push-only channels, each buffered in its own FIFO, merged round-robin onto one registered
// valid/ready output tagged with the source channel. Define MY_MST_DROP_CNT_EN to add drop_cnt.
module my_mst_stream_merger #(
    parameter int DW    = 12,
    parameter int NCH   = 4,
    parameter int DEPTH = 8,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_vld,
    output logic [DW-1:0]     out_data,
    output logic [CHW-1:0]    out_ch,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [NCH-1:0]    ovf,
`ifdef MY_MST_DROP_CNT_EN
    output logic [NCH*8-1:0]  drop_cnt,
`endif
    input  logic              ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic logic fifo_full(input ptr_t wr, input ptr_t rd);
        return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    endfunction

    function automatic logic fifo_empty(input ptr_t wr, input ptr_t rd);
        return (wr == rd);
    endfunction

    function automatic logic [CHW-1:0] rr_index(input logic [CHW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NCH) begin
            sum = sum - NCH;
        end else begin
            sum = sum;
        end
        return CHW'(sum);
    endfunction

    logic [DW-1:0]  mem_q [NCH][DEPTH];
    ptr_t           wr_ptr_q [NCH];
    ptr_t           wr_ptr_d [NCH];
    ptr_t           rd_ptr_q [NCH];
    ptr_t           rd_ptr_d [NCH];

    logic [NCH-1:0] full_s;
    logic [NCH-1:0] empty_s;
    logic [NCH-1:0] push_s;
    logic [NCH-1:0] pop_s;
    logic [NCH-1:0] drop_s;

    logic           load_s;
    logic           found_s;
    logic [CHW-1:0] grant_s;
    logic [DW-1:0]  head_s;

    logic [DW-1:0]  out_data_q, out_data_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;
    logic           out_vld_q, out_vld_d;
    logic [CHW-1:0] rr_q, rr_d;
    logic [NCH-1:0] ovf_q, ovf_d;

    // Per-channel FIFO status flags.
    always_comb begin
        full_s  = '0;
        empty_s = '0;
        for (int i = 0; i < NCH; i++) begin
            full_s[i]  = fifo_full(wr_ptr_q[i], rd_ptr_q[i]);
            empty_s[i] = fifo_empty(wr_ptr_q[i], rd_ptr_q[i]);
        end
    end

    // Round-robin arbiter: first non-empty FIFO after the last grant.
    always_comb begin
        load_s  = !out_vld_q || out_rdy;
        found_s = 1'b0;
        grant_s = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!found_s && !empty_s[rr_index(rr_q, k)]) begin
                found_s = 1'b1;
                grant_s = rr_index(rr_q, k);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Head word of the granted FIFO.
    always_comb begin
        head_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_s == CHW'(i)) begin
                head_s = mem_q[i][rd_ptr_q[i][AW-1:0]];
            end else begin
                head_s = head_s;
            end
        end
    end

    // A full FIFO still accepts a word when its head leaves at the same edge.
    always_comb begin
        pop_s  = '0;
        push_s = '0;
        drop_s = '0;
        for (int i = 0; i < NCH; i++) begin
            pop_s[i]  = load_s && found_s && (grant_s == CHW'(i));
            push_s[i] = in_vld[i] && (!full_s[i] || pop_s[i]);
            drop_s[i] = in_vld[i] && full_s[i] && !pop_s[i];
        end
    end

    // FIFO pointer next-state.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (push_s[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i];
            end
            if (pop_s[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
            end else begin
                rd_ptr_d[i] = rd_ptr_q[i];
            end
        end
    end

    // Output register, RR pointer and sticky overflow next-state.
    always_comb begin
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_vld_d  = out_vld_q;
        rr_d       = rr_q;
        if (load_s) begin
            if (found_s) begin
                out_data_d = head_s;
                out_ch_d   = grant_s;
                out_vld_d  = 1'b1;
                rr_d       = grant_s;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else begin
            out_vld_d = out_vld_q;
        end
        if (ovf_clr) begin
            ovf_d = drop_s;
        end else begin
            ovf_d = ovf_q | drop_s;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push_s[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_data[i*DW +: DW];
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_vld_q  <= 1'b0;
            rr_q       <= CHW'(NCH - 1);
            ovf_q      <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_vld_q  <= out_vld_d;
            rr_q       <= rr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ch   = out_ch_q;
    assign out_vld  = out_vld_q;
    assign ovf      = ovf_q;

`ifdef MY_MST_DROP_CNT_EN
    logic [7:0] cnt_q [NCH];
    logic [7:0] cnt_d [NCH];

    // Saturating drop counters; a drop coinciding with a clear leaves a count of one.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ovf_clr) begin
                cnt_d[i] = drop_s[i] ? 8'd1 : 8'd0;
            end else if (drop_s[i] && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters onto the output port.
    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            drop_cnt[i*8 +: 8] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_my_mst_stream_merger.sv
// Scoreboard bench for my_mst_stream_merger (DW=12, NCH=4, DEPTH=8); directed stimulus pushes
// expected words into a queue, a negedge monitor pops and compares each accepted output word.
module tb_my_mst_stream_merger;

    localparam int DW  = 12;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic              clk;
    logic              rst_n;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_vld;
    logic [DW-1:0]     out_data;
    logic [CHW-1:0]    out_ch;
    logic              out_vld;
    logic              out_rdy;
    logic [NCH-1:0]    ovf;
    logic              ovf_clr;
`ifdef MY_MST_DROP_CNT_EN
    logic [NCH*8-1:0]  drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int exp_ch_q[$];
    int exp_data_q[$];

    my_mst_stream_merger #(.DW(DW), .NCH(NCH), .DEPTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .ovf      (ovf),
`ifdef MY_MST_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int ch, input int data);
        exp_ch_q.push_back(ch);
        exp_data_q.push_back(data);
    endtask

    task automatic drive_ch(input int ch, input logic [DW-1:0] data);
        in_vld          = '0;
        in_data         = '0;
        in_vld[ch]      = 1'b1;
        in_data[ch*DW +: DW] = data;
    endtask

    task automatic drain(input string name);
        out_rdy = 1'b1;
        in_vld  = '0;
        for (int c = 0; c < 60 && exp_data_q.size() != 0; c++) begin
            step();
        end
        chk(name, exp_data_q.size(), 0);
        step();
        chk({name, "_idle"}, out_vld, 0);
    endtask

    // Monitor: checks every accepted word against the scoreboard and holds during stalls.
    initial begin
        logic          stall;
        logic [DW-1:0] hold_data;
        logic [CHW-1:0] hold_ch;
        int            e_ch;
        int            e_data;
        stall = 1'b0;
        hold_data = '0;
        hold_ch = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_vld", out_vld, 1);
                    chk("hold_data", out_data, hold_data);
                    chk("hold_ch", out_ch, hold_ch);
                end
                if (out_vld && out_rdy) begin
                    if (exp_data_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_word: got ch %0d data %0h, expected none", out_ch, out_data);
                    end else begin
                        e_ch   = exp_ch_q.pop_front();
                        e_data = exp_data_q.pop_front();
                        chk("sb_ch", out_ch, e_ch);
                        chk("sb_data", out_data, e_data);
                    end
                end
                stall     = out_vld && !out_rdy;
                hold_data = out_data;
                hold_ch   = out_ch;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        in_vld  = '0;
        in_data = '0;
        out_rdy = 1'b0;
        ovf_clr = 1'b0;

        // Reset values, during and after reset.
        repeat (3) step();
        chk("t1_rst_vld", out_vld, 0);
        chk("t1_rst_ovf", ovf, 0);
        chk("t1_rst_data", out_data, 0);
        chk("t1_rst_ch", out_ch, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("t1_rel_vld", out_vld, 0);
        chk("t1_rel_ovf", ovf, 0);
        chk("t1_rel_data", out_data, 0);

        // All four channels at once: channel 0 first, one edge after the push.
        out_rdy = 1'b1;
        in_vld  = 4'b1111;
        in_data = {12'h00D, 12'h00C, 12'h00B, 12'h00A};
        expect_word(0, 12'h00A);
        expect_word(1, 12'h00B);
        expect_word(2, 12'h00C);
        expect_word(3, 12'h00D);
        step();
        in_vld = '0;
        chk("t2_no_bypass", out_vld, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_vld", out_vld, 1);
            chk("t2_ch", out_ch, i);
        end
        drain("t2_drain");

        // Stalled output: the output register holds one word, so the tenth push drops.
        out_rdy = 1'b0;
        for (int j = 0; j < 10; j++) begin
            drive_ch(2, 12'h200 + DW'(j));
            if (j < 9) expect_word(2, 12'h200 + j);
            step();
            chk("t3_ovf", ovf, (j == 9) ? 4'b0100 : 4'b0000);
        end
        in_vld = '0;
        chk("t3_hold_vld", out_vld, 1);
        chk("t3_hold_word0", out_data, 12'h200);
        chk("t3_hold_ch", out_ch, 2);
`ifdef MY_MST_DROP_CNT_EN
        chk("t3_drop_cnt", drop_cnt[2*8 +: 8], 1);
`endif
        repeat (3) step();
        drain("t3_drain");
        chk("t3_ovf_sticky", ovf, 4'b0100);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", ovf, 0);

        // Full FIFO accepts a push at the same edge its head is popped.
        out_rdy = 1'b0;
        for (int j = 0; j < 9; j++) begin
            drive_ch(1, 12'h100 + DW'(j));
            expect_word(1, 12'h100 + j);
            step();
        end
        chk("t4_full_no_ovf", ovf, 0);
        out_rdy = 1'b1;
        drive_ch(1, 12'h109);
        expect_word(1, 12'h109);
        step();
        in_vld = '0;
        chk("t4_ovf", ovf, 0);
        chk("t4_next_data", out_data, 12'h101);
        chk("t4_next_ch", out_ch, 1);
        drain("t4_drain");

        // Channels 0 and 3 alternate under a toggling out_rdy.
        for (int j = 0; j < 5; j++) begin
            expect_word(0, 12'h0A0 + j);
            expect_word(3, 12'h3B0 + j);
        end
        expect_word(0, 12'h0A5);
        out_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_vld  = '0;
            in_data = '0;
            in_vld[0] = 1'b1;
            in_data[0 +: DW] = 12'h0A0 + DW'(c);
            if (c >= 1) begin
                in_vld[3] = 1'b1;
                in_data[3*DW +: DW] = 12'h3B0 + DW'(c - 1);
            end
            step();
            out_rdy = ~out_rdy;
        end
        in_vld = '0;
        for (int c = 0; c < 24; c++) begin
            step();
            out_rdy = ~out_rdy;
        end
        drain("t5_drain");
        chk("t5_ovf", ovf, 0);

        // Clear coinciding with a drop keeps the flag; a plain clear empties it.
        out_rdy = 1'b0;
        for (int j = 0; j < 10; j++) begin
            drive_ch(0, 12'h300 + DW'(j));
            if (j < 9) expect_word(0, 12'h300 + j);
            step();
        end
        chk("t6_ovf_set", ovf, 4'b0001);
        drive_ch(0, 12'h3FF);
        ovf_clr = 1'b1;
        step();
        in_vld  = '0;
        ovf_clr = 1'b0;
        chk("t6_clr_with_drop", ovf, 4'b0001);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t6_clr_plain", ovf, 0);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
